// File: rtl/reg_dump.sv
// reg_dump: debug read-out engine for the RiSC-16 register file.
//
// On a start pulse it walks register indices 0..p_REG_FILE_SIZE-1 through one
// asynchronous read port, captures each word into a data register, and streams
// it out to a debug host over a valid/ready interface. While busy it owns the
// register-file read address, so the core must be halted during a dump.
//
// Ports:
//   i_clk, i_rst_n   clock (posedge) and asynchronous active-low reset
//   i_start          request a dump (only honoured in IDLE, and not with abort)
//   i_abort          cancel a dump in progress
//   o_rd_addr        register file read address (0 in IDLE, idx otherwise)
//   i_rd_data        asynchronous read data for o_rd_addr
//   o_valid/i_ready  output handshake
//   o_data, o_idx    captured word and its register index (0 outside SEND)
//   o_last           o_valid beat carries the final index
//   o_busy           engine is not IDLE
//   o_done           one-cycle pulse on normal completion
//
// Handshake: a beat transfers on a clock edge where o_valid and i_ready are
// both high. o_valid never depends on i_ready, and once o_valid is raised
// o_data/o_idx hold steady until the transfer (or an abort/reset) happens.

module reg_dump #(
  parameter int p_WORD_LEN      = 16,
  parameter int p_REG_ADDR_LEN  = 3,
  parameter int p_REG_FILE_SIZE = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  output logic [p_REG_ADDR_LEN-1:0] o_rd_addr,
  input  logic [p_WORD_LEN-1:0]     i_rd_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [p_WORD_LEN-1:0]     o_data,
  output logic [p_REG_ADDR_LEN-1:0] o_idx,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [p_REG_ADDR_LEN-1:0] lp_LAST_IDX =
    p_REG_ADDR_LEN'(p_REG_FILE_SIZE - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [p_REG_ADDR_LEN-1:0] r_idx;
  logic [p_WORD_LEN-1:0]     r_data;
  logic                      w_at_last;

  assign w_at_last = (r_idx == lp_LAST_IDX);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Abort wins over everything outside IDLE; a transfer
  // that coincides with abort is still considered taken by the host.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = i_abort ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_ready) begin
          // The last index ends the walk, so idx never wraps even when the
          // register count is not a power of two.
          w_state_nxt = w_at_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Index and snapshot registers. The word is captured only in LOAD, so a
  // register write after capture never disturbs the beat being presented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_state_nxt == S_LOAD) begin
        r_idx <= '0;
      end else if (r_state == S_SEND && w_state_nxt == S_LOAD) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == S_LOAD) begin
        r_data <= i_rd_data;
      end
    end
  end

  // Outputs decoded from state and idx only.
  always_comb begin
    o_rd_addr = '0;
    o_valid   = 1'b0;
    o_data    = '0;
    o_idx     = '0;
    o_last    = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_rd_addr = '0;
      end
      S_LOAD: begin
        o_rd_addr = r_idx;
        o_busy    = 1'b1;
      end
      S_SEND: begin
        o_rd_addr = r_idx;
        o_valid   = 1'b1;
        o_data    = r_data;
        o_idx     = r_idx;
        o_last    = w_at_last;
        o_busy    = 1'b1;
      end
      S_DONE: begin
        o_rd_addr = r_idx;
        o_busy    = 1'b1;
        o_done    = 1'b1;
      end
      default: begin
        o_rd_addr = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [2:0]  o_rd_addr;
  logic [15:0] i_rd_data;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic [2:0]  o_idx;
  logic        o_last;
  logic        o_busy;
  logic        o_done;

  // Behavioural register file with an asynchronous read port.
  logic [15:0] rf [8];
  assign i_rd_data = rf[o_rd_addr];

  reg_dump #(
    .p_WORD_LEN     (16),
    .p_REG_ADDR_LEN (3),
    .p_REG_FILE_SIZE(8)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_abort  (i_abort),
    .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_last   (o_last),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [18:0] exp_q[$];  // {idx, data}
  logic [18:0] got_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- monitor (samples on negedge) ----------------
  bit          prev_stall = 1'b0;
  logic [2:0]  prev_idx;
  logic [15:0] prev_data;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (prev_stall) begin
        check("hold valid", 32'(o_valid), 32'd1);
        check("hold idx", 32'(o_idx), 32'(prev_idx));
        check("hold data", 32'(o_data), 32'(prev_data));
      end
      if (o_valid) check("last rule", 32'(o_last), 32'(o_idx == 3'd7));
      else         check("last low", 32'(o_last), 32'd0);
      if (o_valid && i_ready) got_q.push_back({o_idx, o_data});
      if (o_done) done_cnt++;
      prev_stall = o_valid && !i_ready && !i_abort;
      prev_idx   = o_idx;
      prev_data  = o_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) rf[i] = 16'(32'h1111 * i);
  endtask

  task automatic snapshot_expect();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), rf[i]});
  endtask

  task automatic compare_beats(input string tag);
    logic [18:0] e;
    logic [18:0] g;
    check({tag, " beat count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check($sformatf("%s beat %0d", tag, e[18:16]), 32'(g), 32'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic wait_beat(input logic [2:0] idx, output bit found);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (o_valid && o_idx == idx) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done_since(input int d0, input string tag);
    for (int c = 0; c < 300 && done_cnt == d0; c++) tick();
    check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  // mode 0: ready held high; 1: random ready and ignored starts;
  // 2: start pulse at idx 2 and 5-cycle stall on idx 3.
  task automatic run_dump(input int mode, input string tag);
    int done0;
    int stall;
    snapshot_expect();
    got_q.delete();
    done0 = done_cnt;
    stall = 0;
    i_start = 1'b1;
    i_ready = 1'b1;
    tick();
    for (int c = 0; c < 600 && done_cnt == done0; c++) begin
      i_start = 1'b0;
      i_ready = 1'b1;
      if (mode == 1) begin
        i_ready = ($urandom_range(0, 3) != 0);
        if (got_q.size() < 8 && $urandom_range(0, 5) == 0) i_start = 1'b1;
      end
      if (mode == 2) begin
        if (o_valid && o_idx == 3'd2) i_start = 1'b1;
        if (stall == 0 && o_valid && o_idx == 3'd3) stall = 1;
        if (stall >= 1 && stall <= 5) begin
          check({tag, " stall valid"}, 32'(o_valid), 32'd1);
          check({tag, " stall data"}, 32'(o_data), 32'h3333);
          i_ready = 1'b0;
          stall++;
        end
      end
      tick();
    end
    i_start = 1'b0;
    check({tag, " done seen"}, 32'(done_cnt - done0), 32'd1);
    check({tag, " busy falls"}, 32'(o_busy), 32'd0);
    if (mode == 2) check({tag, " stall cycles"}, 32'(stall), 32'd6);
    i_ready = 1'b1;
    repeat (3) tick();
    check({tag, " single done"}, 32'(done_cnt - done0), 32'd1);
    check({tag, " stays idle"}, 32'(o_busy), 32'd0);
    compare_beats(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start, abort, ready;
    logic        valid, last, busy, done, chk_addr;
    logic [2:0]  idx, addr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[19];
  vec_t v_tmp;

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    int d0;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_ready = 1'b0;
    preload();

    // Reset state
    #3;
    check("rst valid", 32'(o_valid), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst last", 32'(o_last), 32'd0);
    check("rst addr", 32'(o_rd_addr), 32'd0);
    check("rst data", 32'(o_data), 32'd0);
    check("rst idx", 32'(o_idx), 32'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    check("idle busy", 32'(o_busy), 32'd0);
    check("idle addr", 32'(o_rd_addr), 32'd0);

    // Table: start+abort in IDLE, then a full dump with ready held high.
    // Row k+1 holds the outputs seen in the cycle after the k-th edge
    // counted from the start edge: LOAD/SEND alternate, DONE then IDLE.
    tbl[0] = '{start: 1'b1, abort: 1'b1, ready: 1'b1, valid: 1'b0,
               last: 1'b0, busy: 1'b0, done: 1'b0, chk_addr: 1'b1,
               idx: 3'd0, addr: 3'd0, data: 16'h0};
    for (int k = 0; k < 18; k++) begin
      v_tmp = '{start: 1'b0, abort: 1'b0, ready: 1'b1, valid: 1'b0,
                last: 1'b0, busy: 1'b0, done: 1'b0, chk_addr: 1'b1,
                idx: 3'd0, addr: 3'd0, data: 16'h0};
      v_tmp.start = (k == 0);
      if (k < 16) begin
        v_tmp.busy = 1'b1;
        v_tmp.addr = 3'(k / 2);
        if (k % 2 == 1) begin
          v_tmp.valid = 1'b1;
          v_tmp.idx   = 3'(k / 2);
          v_tmp.data  = 16'(32'h1111 * (k / 2));
          v_tmp.last  = (k / 2 == 7);
        end
      end else if (k == 16) begin
        v_tmp.busy     = 1'b1;
        v_tmp.done     = 1'b1;
        v_tmp.chk_addr = 1'b0;
      end
      tbl[k + 1] = v_tmp;
    end

    for (int r = 0; r < 19; r++) begin
      i_start = tbl[r].start;
      i_abort = tbl[r].abort;
      i_ready = tbl[r].ready;
      tick();
      check($sformatf("vec%0d valid", r), 32'(o_valid), 32'(tbl[r].valid));
      check($sformatf("vec%0d last", r), 32'(o_last), 32'(tbl[r].last));
      check($sformatf("vec%0d busy", r), 32'(o_busy), 32'(tbl[r].busy));
      check($sformatf("vec%0d done", r), 32'(o_done), 32'(tbl[r].done));
      check($sformatf("vec%0d idx", r), 32'(o_idx), 32'(tbl[r].idx));
      check($sformatf("vec%0d data", r), 32'(o_data), 32'(tbl[r].data));
      if (tbl[r].chk_addr)
        check($sformatf("vec%0d addr", r), 32'(o_rd_addr), 32'(tbl[r].addr));
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    got_q.delete();

    // Backpressure on idx 3 plus an ignored start at idx 2
    run_dump(2, "backpressure");

    // Abort in SEND at idx 4, then a fresh full dump
    d0 = done_cnt;
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_beat(3'd4, found);
    check("abort reached idx4", 32'(found), 32'd1);
    i_abort = 1'b1;
    i_ready = 1'b0;
    tick();
    i_abort = 1'b0;
    check("abort valid", 32'(o_valid), 32'd0);
    check("abort busy", 32'(o_busy), 32'd0);
    repeat (3) tick();
    check("abort no done", 32'(done_cnt - d0), 32'd0);
    check("abort idle", 32'(o_busy), 32'd0);
    got_q.delete();
    run_dump(0, "after abort");

    // Snapshot: r6 rewritten while beat 6 is stalled
    snapshot_expect();
    got_q.delete();
    d0 = done_cnt;
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_beat(3'd6, found);
    check("snap reached idx6", 32'(found), 32'd1);
    i_ready = 1'b0;
    rf[6] = 16'hBEEF;
    repeat (3) begin
      tick();
      check("snap held data", 32'(o_data), 32'h6666);
    end
    i_ready = 1'b1;
    wait_done_since(d0, "snap");
    tick();
    compare_beats("snap");
    run_dump(0, "post snap");

    // Asynchronous reset mid-dump at idx 5
    preload();
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_beat(3'd5, found);
    check("rst reached idx5", 32'(found), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid rst valid", 32'(o_valid), 32'd0);
    check("mid rst busy", 32'(o_busy), 32'd0);
    check("mid rst done", 32'(o_done), 32'd0);
    check("mid rst last", 32'(o_last), 32'd0);
    check("mid rst addr", 32'(o_rd_addr), 32'd0);
    check("mid rst data", 32'(o_data), 32'd0);
    check("mid rst idx", 32'(o_idx), 32'd0);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    tick();
    check("post rst busy", 32'(o_busy), 32'd0);
    check("post rst addr", 32'(o_rd_addr), 32'd0);
    repeat (3) tick();
    check("post rst no resume", 32'(o_busy), 32'd0);
    got_q.delete();

    // Randomized dumps against the snapshot model
    for (int n = 0; n < 6; n++) begin
      rf[0] = 16'h0;
      for (int i = 1; i < 8; i++) rf[i] = 16'($urandom);
      run_dump(1, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the RiSC-16 pipelined core's register file. On a start pulse it walks every register index in order through one asynchronous read port and streams each word out on a valid/ready interface. The target is a debug/UART host link. It sits beside the register file and, while busy, owns the read address that decode normally drives; the core must be halted while `o_busy` is high.

## Interface
- `p_WORD_LEN`, 16, register word width
- `p_REG_ADDR_LEN`, 3, register index width
- `p_REG_FILE_SIZE`, 8, number of registers dumped (indices 0..p_REG_FILE_SIZE-1)

Ports:
- `i_clk`  in  1  clock; all state updates on posedge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  request a dump; sampled only in IDLE
- `i_abort`  in  1  cancel a dump in progress
- `o_rd_addr`  out  p_REG_ADDR_LEN  register file read address
- `i_rd_data`  in  p_WORD_LEN  asynchronous read data for `o_rd_addr`
- `o_valid`  out  1  `o_data`/`o_idx` hold a word for the host
- `i_ready`  in  1  host accepts the word when high together with `o_valid`
- `o_data`  out  p_WORD_LEN  captured register value
- `o_idx`  out  p_REG_ADDR_LEN  index of `o_data`
- `o_last`  out  1  high with `o_valid` when `o_idx == p_REG_FILE_SIZE-1`
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse on normal completion

## Operation
- FSM states are IDLE, LOAD, SEND and DONE, held in a state register.
- Index register `idx` is p_REG_ADDR_LEN bits. Data register `data_q` is p_WORD_LEN bits.
- **IDLE:**
  - `o_rd_addr`=0, `o_busy`=0.
  - `i_start`=1 and `i_abort`=0: `idx`<=0, go to LOAD.
- **LOAD:**
  - `o_rd_addr`=`idx`; `data_q`<=`i_rd_data`; go to SEND.
  - This is exactly one cycle per word.
- **SEND:**
  - `o_valid`=1, `o_data`=`data_q`, `o_idx`=`idx`, `o_rd_addr`=`idx`.
  - `o_data` and `o_idx` are stable while `o_valid` && !`i_ready`.
  - On `o_valid`&&`i_ready` with `idx`==p_REG_FILE_SIZE-1: go to DONE.
  - On `o_valid`&&`i_ready` otherwise: `idx`<=`idx`+1, go to LOAD.
  - The index never wraps. For a non-power-of-two size the last index terminates the walk.
- **DONE:** `o_done`=1 for this one cycle, `o_busy`=1, then IDLE.
- **Abort:**
  - `i_abort`=1 in LOAD, SEND or DONE: go to IDLE next cycle.
  - `o_valid` is low from that cycle; no `o_done` pulse.
  - A transfer that coincides with abort in SEND is counted as accepted by the host. The engine still goes to IDLE.
- **Busy behaviour:**
  - `i_start` while busy is ignored; it is not queued.
  - `i_start` and `i_abort` together in IDLE: stay IDLE.
- **Snapshot semantics:** the value is captured in LOAD. A register write after capture is not reflected in the word being sent. Index 0 reports whatever the register file returns, which is 0.
- **Outputs:** `o_valid`, `o_last` and `o_done` are decoded from state and `idx` only, never from `i_ready`. `o_data`/`o_idx` read 0 in IDLE.

## Timing
- **Reset (`i_rst_n`=0, asynchronous):**
  - state=IDLE, `idx`=0, `data_q`=0.
  - `o_valid`=`o_busy`=`o_done`=`o_last`=0, `o_rd_addr`=0, `o_data`=0, `o_idx`=0.
  - This applies immediately, including mid-dump. After release no dump resumes.
- **Start latency:**
  - `i_start` high at edge N: LOAD during cycle N+1, first `o_valid` during cycle N+2.
- **Throughput:** 2 cycles per word minimum (LOAD + SEND with `i_ready` high).
- **Full dump with `i_ready` held high:** 1 + 2·p_REG_FILE_SIZE cycles from the start edge to the DONE cycle. With the default of 8 registers, `o_done` is high in cycle N+17.
- **Read path:** `o_rd_addr` is registered-derived (from `idx`/state). The `i_rd_data` combinational path is register file read only, captured at the LOAD→SEND edge.

## Test plan
- **Preload and full dump:** preload r1..r7 = 0x1111·i with r0=0; pulse start with `i_ready`=1 -> eight beats, `o_idx` 0..7 with `o_data` 0x0000,0x1111..0x7777; `o_last` only on idx 7; `o_done` 17 cycles after start; `o_busy` falls the cycle after.
- **Backpressure:** same preload; hold `i_ready`=0 for 5 cycles on idx 3 -> `o_valid`=1 and `o_data`=0x3333 stable all 5 cycles; no beat skipped or duplicated; 8 beats total.
- **Abort:** `i_abort` in SEND at idx 4 -> `o_valid`/`o_busy` low next cycle, no `o_done`. A new start then yields a full 0..7 dump.
- **Start ignored while busy:** pulse `i_start` during idx 2 -> no restart, exactly 8 beats, one `o_done`.
- **Reset mid-dump:** assert `i_rst_n`=0 asynchronously at idx 5 -> all outputs 0 before the next edge; after release, IDLE with `o_rd_addr`=0.
- **Snapshot:** write r6=0xBEEF the cycle after idx 6 is captured while `i_ready`=0 -> beat 6 reports 0x6666; the next dump reports 0xBEEF.
